// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: bus layouts, mem_op encoding, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The packed struct layouts define the bus field offsets. The first member
// sits in the MSBs:
//   exe: pc[106:75] alu_result[74:43] store_data[42:11] mem_op[10:6] rd[5:1] reg_we[0]
//   mem: pc[69:38] wb_data[37:6] rd[5:1] reg_we[0]
package mem_stage_pkg;

  localparam int EXE_W_DEF = 107;
  localparam int MEM_W_DEF = 70;

  // Access size. The encoding 11 behaves as a word access.
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORD2 = 2'b11
  } mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      we;
    logic      is_unsigned;
    mem_size_e size;
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    mem_op_t     mem_op;
    logic [4:0]  rd;
    logic        reg_we;
  } exe_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // The data memory is addressed by word. The low bits only select lanes.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: a single request channel (valid/ready) plus a response strobe.
// Latency: n/a (wiring only).
// Backpressure: the memory stalls requests with data_req_ready. Responses have no backpressure.
// master: the memory stage drives the request and receives the response.
// slave : the data memory (or a bench model) receives the request and drives the response.
interface mem_stage_if;
  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_req_we;
  logic [31:0] data_req_addr;
  logic [31:0] data_req_wdata;
  logic [3:0]  data_req_wstrb;
  logic        data_resp_valid;
  logic [31:0] data_resp_rdata;

  modport master (
    output data_req_valid, data_req_we, data_req_addr, data_req_wdata, data_req_wstrb,
    input  data_req_ready, data_resp_valid, data_resp_rdata
  );

  modport slave (
    input  data_req_valid, data_req_we, data_req_addr, data_req_wdata, data_req_wstrb,
    output data_req_ready, data_resp_valid, data_resp_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication and strobes, load lane select and extension.
// Latency: purely combinational.
// Backpressure: none.
// Ports: addr_lo_i (address bits [1:0]), size_i, unsigned_i, store_data_i, rdata_i ->
//        wdata_o, wstrb_o (store side), load_data_o (load side).
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    wdata_o     = store_data_i;
    wstrb_o     = 4'b1111;
    lane_b      = 8'h00;
    lane_h      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_data_o = rdata_i;

    // Store data is replicated to every lane. The strobes select the lanes that are written.
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{store_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
      end
      default: ;
    endcase

    case (addr_lo_i)
      2'd0:    lane_b = rdata_i[7:0];
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase

    case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_data_o = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU ops through and runs one load/store per op against the data memory.
// Latency: non-memory op 1 cycle; memory op 1 + request stall + response wait + 1 cycles.
// Backpressure: left_ready drops while an op is held and not leaving. At most one memory request is outstanding.
// Ports: clk, reset (async, active-low); exe_ctrl_bus/left_valid/left_ready from execute;
//        mem_ctrl_bus/right_valid/right_ready toward write-back; dmem data-memory master port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EXE_W = EXE_W_DEF,
  parameter int MEM_W = MEM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EXE_W-1:0] exe_ctrl_bus,
  input  logic             left_valid,
  output logic             left_ready,
  output logic [MEM_W-1:0] mem_ctrl_bus,
  output logic             right_valid,
  input  logic             right_ready,
  mem_stage_if.master      dmem
);

  exe_bus_t ex;
  assign ex = exe_bus_t'(exe_ctrl_bus);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_we_q, reg_we_d;
  mem_size_e   size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        is_store_q, is_store_d;
  logic [31:0] wb_q, wb_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;

  logic [1:0]  align_lo;
  mem_size_e   align_size;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_data;

  // A single aligner serves both directions. While waiting for the response it
  // sees the latched op for the load path. Otherwise it sees the incoming op, so
  // the store lanes can be registered at the moment the op is accepted.
  assign align_lo   = (state_q == ST_WAIT) ? alu_q[1:0] : ex.alu_result[1:0];
  assign align_size = (state_q == ST_WAIT) ? size_q : ex.mem_op.size;

  mem_lane_align u_align (
    .addr_lo_i    (align_lo),
    .size_i       (align_size),
    .unsigned_i   (unsigned_q),
    .store_data_i (ex.store_data),
    .rdata_i      (dmem.data_resp_rdata),
    .wdata_o      (st_wdata),
    .wstrb_o      (st_wstrb),
    .load_data_o  (ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    rd_d        = rd_q;
    reg_we_d    = reg_we_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    is_store_d  = is_store_q;
    wb_d        = wb_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    left_ready  = 1'b0;

    case (state_q)
      ST_IDLE: left_ready = 1'b1;
      ST_REQ:  if (dmem.data_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        // Responses are honoured only here, so a stray or late ack cannot complete an op.
        if (dmem.data_resp_valid) begin
          state_d = ST_DONE;
          wb_d    = is_store_q ? alu_q : ld_data;
        end
      end
      ST_DONE: begin
        if (right_ready) begin
          left_ready = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accepting a new op overrides the exit to IDLE. This gives back-to-back flow from DONE.
    if (left_valid && left_ready) begin
      pc_d       = ex.pc;
      alu_d      = ex.alu_result;
      rd_d       = ex.rd;
      reg_we_d   = ex.reg_we;
      size_d     = ex.mem_op.size;
      unsigned_d = ex.mem_op.is_unsigned;
      is_store_d = ex.mem_op.we;
      wb_d       = ex.alu_result;
      if (ex.mem_op.is_mem) begin
        state_d     = ST_REQ;
        req_we_d    = ex.mem_op.we;
        req_addr_d  = word_addr(ex.alu_result);
        req_wdata_d = ex.mem_op.we ? st_wdata : 32'h0;
        req_wstrb_d = ex.mem_op.we ? st_wstrb : 4'h0;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      alu_q       <= '0;
      rd_q        <= '0;
      reg_we_q    <= 1'b0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
      is_store_q  <= 1'b0;
      wb_q        <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else begin
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      reg_we_q    <= reg_we_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      is_store_q  <= is_store_d;
      wb_q        <= wb_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
    end
  end

  assign right_valid         = (state_q == ST_DONE);
  assign mem_ctrl_bus        = {pc_q, wb_q, rd_q, reg_we_q};
  assign dmem.data_req_valid = (state_q == ST_REQ);
  assign dmem.data_req_we    = req_we_q;
  assign dmem.data_req_addr  = req_addr_q;
  assign dmem.data_req_wdata = req_wdata_q;
  assign dmem.data_req_wstrb = req_wstrb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model and a per-cycle compare.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [106:0] exe_ctrl_bus;
  logic         left_valid;
  logic         left_ready;
  logic [69:0]  mem_ctrl_bus;
  logic         right_valid;
  logic         right_ready;
  int           checks = 0;
  int           errors = 0;
  bit           cmp_en = 1'b0;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk          (clk),
    .reset        (rst_n),
    .exe_ctrl_bus (exe_ctrl_bus),
    .left_valid   (left_valid),
    .left_ready   (left_ready),
    .mem_ctrl_bus (mem_ctrl_bus),
    .right_valid  (right_valid),
    .right_ready  (right_ready),
    .dmem         (dmem.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out waiting for DUT", nm);
  endtask

  function automatic logic [106:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                      input logic [31:0] sd, input logic [4:0] op,
                                      input logic [4:0] rd, input logic we);
    return {pc, alu, sd, op, rd, we};
  endfunction

  // ---------------- reference model (spec rules, transaction level) ----------------
  function automatic logic [3:0] f_wstrb(input logic [4:0] op, input logic [31:0] a);
    if (!op[3]) return 4'h0;
    case (op[1:0])
      2'b00:   return 4'(1 << a[1:0]);
      2'b01:   return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [4:0] op, input logic [31:0] sd);
    if (!op[3]) return 32'h0;
    case (op[1:0])
      2'b00:   return 32'(sd[7:0]) * 32'h0101_0101;
      2'b01:   return 32'(sd[15:0]) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] f_wb(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] rdata);
    logic [31:0] sh;
    if (!op[4] || op[3]) return a;
    case (op[1:0])
      2'b00: begin
        sh = rdata >> (8 * a[1:0]);
        return op[2] ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
      end
      2'b01: begin
        sh = rdata >> (16 * a[1]);
        return op[2] ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
      end
      default: return rdata;
    endcase
  endfunction

  // The model holds at most one op. It tracks whether the op's request has been
  // taken and whether its result exists yet.
  bit           m_busy = 1'b0;
  bit           m_req_sent = 1'b0;
  bit           m_result = 1'b0;
  logic [106:0] m_op = '0;
  logic [31:0]  m_rdata = '0;

  function automatic bit m_left_ready();
    return !m_busy || (m_result && right_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit lf;
    if (!rst_n) begin
      m_busy = 1'b0; m_req_sent = 1'b0; m_result = 1'b0;
    end else begin
      lf = left_valid && m_left_ready();
      if (m_busy && m_result && right_ready) begin
        m_busy = 1'b0; m_result = 1'b0;
      end else if (m_busy && m_op[10] && !m_req_sent && dmem.data_req_ready) begin
        m_req_sent = 1'b1;
      end else if (m_busy && m_req_sent && !m_result && dmem.data_resp_valid) begin
        m_result = 1'b1;
        m_rdata  = dmem.data_resp_rdata;
      end
      if (lf) begin
        m_op = exe_ctrl_bus; m_busy = 1'b1; m_req_sent = 1'b0; m_result = !exe_ctrl_bus[10];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit exp_req, exp_rv;
      exp_req = m_busy && m_op[10] && !m_req_sent;
      exp_rv  = m_busy && m_result;
      chk("left_ready", 70'(left_ready), 70'(m_left_ready()));
      chk("req_valid", 70'(dmem.data_req_valid), 70'(exp_req));
      chk("right_valid", 70'(right_valid), 70'(exp_rv));
      if (exp_req) begin
        chk("req_addr", 70'(dmem.data_req_addr), 70'(m_op[74:43] & 32'hFFFF_FFFC));
        chk("req_we", 70'(dmem.data_req_we), 70'(m_op[9]));
        chk("req_wdata", 70'(dmem.data_req_wdata), 70'(f_wdata(m_op[10:6], m_op[42:11])));
        chk("req_wstrb", 70'(dmem.data_req_wstrb), 70'(f_wstrb(m_op[10:6], m_op[74:43])));
      end
      if (exp_rv)
        chk("mem_bus", mem_ctrl_bus,
            {m_op[106:75], f_wb(m_op[10:6], m_op[74:43], m_rdata), m_op[5:1], m_op[0]});
    end
  end

  // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
  task automatic send(input logic [106:0] bus);
    exe_ctrl_bus = bus;
    left_valid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (left_ready) begin
        @(posedge clk); #1;
        left_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    left_valid = 1'b0;
    timeout_fail("send");
  endtask

  task automatic mem_serve(input logic [31:0] rdata, input int dly, input bit resp_in_req,
                           input bit chk_stall, input bit give_resp,
                           output logic [31:0] ra, output logic [31:0] rwd,
                           output logic [3:0] rs, output logic rwe);
    bit seen = 1'b0;
    ra = '0; rwd = '0; rs = '0; rwe = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dmem.data_req_valid) begin
        seen = 1'b1;
        ra = dmem.data_req_addr; rwd = dmem.data_req_wdata;
        rs = dmem.data_req_wstrb; rwe = dmem.data_req_we;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      timeout_fail("mem_req");
      return;
    end
    for (int d = 0; d < dly; d++) begin
      dmem.data_resp_valid = resp_in_req;
      dmem.data_resp_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      if (chk_stall) begin
        chk("stall_left_ready", 70'(left_ready), 70'(0));
        chk("stall_addr", 70'(dmem.data_req_addr), 70'(ra));
      end
      @(posedge clk); #1;
    end
    dmem.data_resp_valid = 1'b0;
    dmem.data_req_ready  = 1'b1;
    @(posedge clk); #1;
    dmem.data_req_ready  = 1'b0;
    if (give_resp) begin
      dmem.data_resp_valid = 1'b1;
      dmem.data_resp_rdata = rdata;
      @(posedge clk); #1;
      dmem.data_resp_valid = 1'b0;
    end
  endtask

  task automatic get_result(output logic [69:0] bus, output int n);
    bus = '0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (right_valid) begin
        bus = mem_ctrl_bus;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    timeout_fail("right_valid");
  endtask

  // Directed memory ops with hand-computed expectations.
  typedef struct {
    logic [31:0] alu; logic [31:0] sd; logic [4:0] op; logic [31:0] rdata;
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic [31:0] wb;
  } vec_t;

  vec_t vecs[9] = '{
    '{32'h103, 32'h0,        5'b10000, 32'h80FF_FF7F, 32'h100, 32'h0,        4'h0, 32'hFFFF_FF80}, // LB
    '{32'h103, 32'h0,        5'b10100, 32'h80FF_FF7F, 32'h100, 32'h0,        4'h0, 32'h0000_0080}, // LBU
    '{32'h202, 32'h0000_ABCD,5'b11001, 32'h0,         32'h200, 32'hABCD_ABCD,4'hC, 32'h0000_0202}, // SH
    '{32'h007, 32'h0000_005A,5'b11000, 32'h0,         32'h004, 32'h5A5A_5A5A,4'h8, 32'h0000_0007}, // SB
    '{32'h402, 32'h0,        5'b10001, 32'h8001_1234, 32'h400, 32'h0,        4'h0, 32'hFFFF_8001}, // LH
    '{32'h400, 32'h0,        5'b10101, 32'h1234_8001, 32'h400, 32'h0,        4'h0, 32'h0000_8001}, // LHU
    '{32'h50C, 32'h1122_3344,5'b11010, 32'h0,         32'h50C, 32'h1122_3344,4'hF, 32'h0000_050C}, // SW
    '{32'h001, 32'h0,        5'b10011, 32'h7654_3210, 32'h000, 32'h0,        4'h0, 32'h7654_3210}, // LW size 11
    '{32'h005, 32'h0,        5'b10000, 32'h0000_7F00, 32'h004, 32'h0,        4'h0, 32'h0000_007F}  // LB lane 1
  };

  initial begin
    logic [69:0] bus, bus0;
    logic [31:0] ra, rwd;
    logic [3:0]  rs;
    logic        rwe;
    int          n;

    rst_n = 1'b0;
    exe_ctrl_bus = '0; left_valid = 1'b0; right_ready = 1'b1;
    dmem.data_req_ready = 1'b0; dmem.data_resp_valid = 1'b0; dmem.data_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_right_valid", 70'(right_valid), 70'(0));
    chk("rst_req_valid", 70'(dmem.data_req_valid), 70'(0));
    chk("rst_left_ready", 70'(left_ready), 70'(1));
    chk("rst_mem_bus", mem_ctrl_bus, 70'(0));
    chk("rst_req_addr", 70'(dmem.data_req_addr), 70'(0));
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Non-memory op: result one cycle after acceptance.
    send(mk(32'h1000, 32'h1234_5678, 32'h0, 5'b00000, 5'd3, 1'b1));
    get_result(bus, n);
    chk("nm_latency", 70'(n), 70'(0));
    chk("nm_wb", 70'(bus[37:6]), 70'(32'h1234_5678));
    chk("nm_rd", 70'(bus[5:1]), 70'(3));
    chk("nm_pc", 70'(bus[69:38]), 70'(32'h1000));

    // Memory op table.
    for (int i = 0; i < 9; i++) begin
      send(mk(32'h4000 + 32'(i * 4), vecs[i].alu, vecs[i].sd, vecs[i].op, 5'(i + 1), 1'b1));
      mem_serve(vecs[i].rdata, 0, 1'b0, 1'b0, 1'b1, ra, rwd, rs, rwe);
      chk("v_addr", 70'(ra), 70'(vecs[i].addr));
      chk("v_wdata", 70'(rwd), 70'(vecs[i].wdata));
      chk("v_wstrb", 70'(rs), 70'(vecs[i].wstrb));
      chk("v_we", 70'(rwe), 70'(vecs[i].op[3]));
      get_result(bus, n);
      chk("v_wb", 70'(bus[37:6]), 70'(vecs[i].wb));
    end

    // Request stalled by data_req_ready; a response during the stall is ignored.
    send(mk(32'h5000, 32'h300, 32'h0, 5'b10010, 5'd9, 1'b1));
    mem_serve(32'hCAFE_F00D, 3, 1'b1, 1'b1, 1'b1, ra, rwd, rs, rwe);
    chk("stall_req_addr", 70'(ra), 70'(32'h300));
    get_result(bus, n);
    chk("stall_wb", 70'(bus[37:6]), 70'(32'hCAFE_F00D));

    // Write-back stalls in DONE, then releases with a new op accepted in the same cycle.
    right_ready = 1'b0;
    send(mk(32'h6000, 32'hA5A5_0001, 32'h0, 5'b00000, 5'd7, 1'b1));
    get_result(bus0, n);
    chk("hold_wb", 70'(bus0[37:6]), 70'(32'hA5A5_0001));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_bus", mem_ctrl_bus, bus0);
      chk("hold_left_ready", 70'(left_ready), 70'(0));
      @(posedge clk); #1;
    end
    right_ready  = 1'b1;
    exe_ctrl_bus = mk(32'h6004, 32'h0BAD_0002, 32'h0, 5'b00000, 5'd8, 1'b1);
    left_valid   = 1'b1;
    @(negedge clk);
    chk("b2b_left_ready", 70'(left_ready), 70'(1));
    @(posedge clk); #1;
    left_valid = 1'b0;
    @(negedge clk);
    chk("b2b_right_valid", 70'(right_valid), 70'(1));
    chk("b2b_wb", 70'(mem_ctrl_bus[37:6]), 70'(32'h0BAD_0002));
    chk("b2b_rd", 70'(mem_ctrl_bus[5:1]), 70'(8));
    @(posedge clk); #1;

    // Reset while waiting for the response.
    send(mk(32'h7000, 32'h600, 32'h0, 5'b10010, 5'd4, 1'b1));
    mem_serve(32'h0, 0, 1'b0, 1'b0, 1'b0, ra, rwd, rs, rwe);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_right_valid", 70'(right_valid), 70'(0));
    chk("arst_req_valid", 70'(dmem.data_req_valid), 70'(0));
    chk("arst_mem_bus", mem_ctrl_bus, 70'(0));
    chk("arst_req_addr", 70'(dmem.data_req_addr), 70'(0));
    chk("arst_req_wstrb", 70'({dmem.data_req_we, dmem.data_req_wstrb, dmem.data_req_wdata}), 70'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem.data_resp_valid = 1'b1;
    dmem.data_resp_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    dmem.data_resp_valid = 1'b0;
    @(negedge clk);
    chk("late_resp_ignored", 70'(right_valid), 70'(0));
    @(posedge clk); #1;
    send(mk(32'h7004, 32'h604, 32'h0, 5'b10010, 5'd6, 1'b1));
    mem_serve(32'h0F0F_0F0F, 1, 1'b0, 1'b0, 1'b1, ra, rwd, rs, rwe);
    get_result(bus, n);
    chk("post_rst_wb", 70'(bus[37:6]), 70'(32'h0F0F_0F0F));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
